mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data memory between the fetch stage (IF) and the load/store stage (LS) of the multi-cycle KGP-RISC core.
- Arbitrates requests, sequences each access through the fixed memory latency, and returns data and completion to the winner.
- Drives a stall to the PC/pipeline-hold logic while any requester is waiting.
- Sits between the core datapath and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en issue to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_rvalid.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high and not yet granted.
- if_gnt  out  1  fetch access issued this cycle.
- if_rvalid  out  1  fetch data valid this cycle.
- if_rdata  out  DATA_W  fetch data; zero when if_rvalid=0.
- ls_req  in  1  load/store request; held high until ls_rvalid.
- ls_we  in  1  1=store, 0=load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  load/store access issued this cycle.
- ls_rvalid  out  1  load data valid, or store complete.
- ls_rdata  out  DATA_W  load data; zero for stores and when ls_rvalid=0.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- stall  out  1  pipeline hold.

Behaviour:
- Reset: synchronous, active-high. Takes effect on the rising clk edge with rst=1.
  - Registered state after reset: state=IDLE, wait counter=0, starvation counter=0, owner=IF.
  - While rst=1, all outputs are forced to 0: gnt, rvalid, rdata, mem_*, stall.
- FSM states:
  - IDLE: may issue.
  - WAIT: counts MEM_LAT cycles.
- Issue, in IDLE with any request high:
  - In the same cycle (combinational): exactly one gnt=1, mem_en=1, mem_addr from the winner.
  - For LS: mem_we=ls_we and mem_wdata=ls_wdata. For IF: mem_we=0.
  - Owner is latched. Next state is WAIT with counter=1.
  - Outside issue cycles, mem_en=mem_we=0 and mem_addr=mem_wdata=0.
- WAIT:
  - Counter increments each cycle.
  - In the cycle where counter==MEM_LAT: owner's rvalid=1, owner's rdata=mem_rdata (0 if LS store). Next state is IDLE.
- Timing:
  - Issue at cycle T gives rvalid at T+MEM_LAT; the next issue is no earlier than T+MEM_LAT+1.
  - Never more than one access outstanding.
- Arbitration, evaluated only in IDLE:
  - Only one requester high: it wins.
  - Both high: LS wins, unless the starvation counter equals STARVE_MAX, in which case IF wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each issue cycle where if_req=1 and LS wins.
  - Clears when IF is granted or when if_req=0 in IDLE.
- Request dropped after grant: the access still completes and rvalid still pulses. A dropped request is not re-served.
- stall = (if_req & ~if_rvalid) | (ls_req & ~ls_rvalid), combinational; 0 when both requests are low.
- Reset mid-WAIT: the in-flight response is discarded. No rvalid is produced; the next cycle is IDLE.

Optional Feature:
- ARB_STATS_EN defined: adds output ports if_gnt_cnt[15:0], ls_gnt_cnt[15:0] and conflict_cnt[15:0].
  - All three are saturating counters, cleared by rst.
  - if_gnt_cnt and ls_gnt_cnt increment on each grant.
  - conflict_cnt increments on each issue cycle with both requests high.
- ARB_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=1 → all outputs 0. First cycle after rst=0: if_gnt=1, mem_addr=if_addr.
- MEM_LAT=2, IF-only, if_addr=0x10, mem_rdata=0xDEADBEEF at T+2 → if_gnt at T, if_rvalid and if_rdata=0xDEADBEEF at T+2, stall=1 for T..T+1, next if_gnt at T+3.
- Both requesting, LS store 0x20/0x55 then LS load 0x24 → ls_gnt first with mem_we=1 and mem_wdata=0x55; ls_rvalid with ls_rdata=0; next issue goes to LS again.
- STARVE_MAX=4, both held high continuously with LS re-requesting → 4 LS grants, then 5th grant goes to IF, then LS resumes.
- rst asserted in cycle T+1 of a MEM_LAT=2 load → no ls_rvalid at T+2; IDLE follows; stall=0 during rst.
- ARB_STATS_EN defined, 3 conflicts and 2 IF-only accesses → conflict_cnt=3, if_gnt_cnt matches number of IF grants; counters hold at 0xFFFF on saturation.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// fetch stage (IF) and the load/store stage (LS) of the multi-cycle KGP-RISC core.
// Only one access is in flight at a time. Each access is issued in IDLE and then
// waits MEM_LAT cycles in WAIT. When both stages request, LS wins unless IF has
// already lost STARVE_MAX times in a row.
// Optional build macro ARB_STATS_EN adds the saturating counters
// if_gnt_cnt, ls_gnt_cnt and conflict_cnt.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       if_gnt_cnt,
    output logic [15:0]       ls_gnt_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_waitCnt;
    logic [2:0]  w_nextWaitCnt;
    logic [3:0]  r_starveCnt;
    logic        r_ownerLs;
    logic        r_ownerStore;
    logic        w_issue;
    logic        w_grantLs;
    logic        w_done;

    // Next-state logic: issue from IDLE, count the memory latency in WAIT.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_issue       = 1'b0;
        w_grantLs     = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    w_issue       = 1'b1;
                    w_grantLs     = ls_req && !(if_req && (r_starveCnt == STARVE_TOP));
                    w_nextState   = ST_WAIT;
                    w_nextWaitCnt = 3'd1;
                end
            end
            ST_WAIT: begin
                if (r_waitCnt == LAT_LAST) begin
                    w_done        = 1'b1;
                    w_nextState   = ST_IDLE;
                    w_nextWaitCnt = 3'd0;
                end else begin
                    w_nextWaitCnt = r_waitCnt + 3'd1;
                end
            end
            default: begin
                w_nextState   = ST_IDLE;
                w_nextWaitCnt = 3'd0;
            end
        endcase
    end

    // Output decode: everything is held at zero while reset is asserted.
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        stall     = 1'b0;
        if (!rst) begin
            if (w_issue) begin
                mem_en = 1'b1;
                if (w_grantLs) begin
                    ls_gnt    = 1'b1;
                    mem_we    = ls_we;
                    mem_addr  = ls_addr;
                    mem_wdata = ls_wdata;
                end else begin
                    if_gnt   = 1'b1;
                    mem_addr = if_addr;
                end
            end
            if (w_done) begin
                if (r_ownerLs) begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = r_ownerStore ? '0 : mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end
            stall = (if_req && !if_rvalid) || (ls_req && !ls_rvalid);
        end
    end

    // State, latency counter, owner and IF starvation tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_waitCnt    <= 3'd0;
            r_starveCnt  <= 4'd0;
            r_ownerLs    <= 1'b0;
            r_ownerStore <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            if (w_issue) begin
                r_ownerLs    <= w_grantLs;
                r_ownerStore <= w_grantLs && ls_we;
            end
            if (w_issue && !w_grantLs) begin
                r_starveCnt <= 4'd0;
            end else if (w_issue && if_req) begin
                if (r_starveCnt != STARVE_TOP) begin
                    r_starveCnt <= r_starveCnt + 4'd1;
                end
            end else if ((r_state == ST_IDLE) && !if_req) begin
                r_starveCnt <= 4'd0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_ifGntCnt;
    logic [15:0] r_lsGntCnt;
    logic [15:0] r_conflictCnt;

    // Saturating grant and conflict counters for performance visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifGntCnt    <= 16'd0;
            r_lsGntCnt    <= 16'd0;
            r_conflictCnt <= 16'd0;
        end else if (w_issue) begin
            if (!w_grantLs && (r_ifGntCnt != 16'hFFFF)) begin
                r_ifGntCnt <= r_ifGntCnt + 16'd1;
            end
            if (w_grantLs && (r_lsGntCnt != 16'hFFFF)) begin
                r_lsGntCnt <= r_lsGntCnt + 16'd1;
            end
            if (if_req && ls_req && (r_conflictCnt != 16'hFFFF)) begin
                r_conflictCnt <= r_conflictCnt + 16'd1;
            end
        end
    end

    assign if_gnt_cnt   = r_ifGntCnt;
    assign ls_gnt_cnt   = r_lsGntCnt;
    assign conflict_cnt = r_conflictCnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
// A cycle-level model built on issue times and a unified memory array predicts
// every output. Literal checks at known cycles pin that model.
// Define ARB_STATS_EN to also check the statistics counters.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req = 1'b0;
    logic              ls_we = 1'b0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic              ls_gnt, ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall;
`ifdef ARB_STATS_EN
    logic [15:0]       if_gnt_cnt, ls_gnt_cnt, conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
`ifdef ARB_STATS_EN
        ,
        .if_gnt_cnt(if_gnt_cnt), .ls_gnt_cnt(ls_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    // Free-running clock; stimulus changes on the falling edge.
    always #5 clk = ~clk;

    // Requester agents: pending work and what was seen last cycle.
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsOp_t;

    logic [ADDR_W-1:0] ifQ[$];
    logic              ifDropQ[$];
    lsOp_t             lsQ[$];
    logic              ifActive = 1'b0;
    logic              ifCurDrop = 1'b0;
    logic              lsActive = 1'b0;
    logic              sIfRvalid = 1'b0;
    logic              sIfGnt = 1'b0;
    logic              sLsRvalid = 1'b0;

    // Physical memory behind the DUT and the model's view of the same memory.
    logic [DATA_W-1:0] physMem[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] modelMem[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] respSched[int];

    // Model state: access in flight, when it was issued, its owner and result.
    int                cycleNo = 0;
    logic              mBusy = 1'b0;
    int                mIssueCyc = 0;
    logic              mOwnerLs = 1'b0;
    logic              mStore = 1'b0;
    logic [DATA_W-1:0] mData = '0;
    int                mLosses = 0;
`ifdef ARB_STATS_EN
    logic [15:0]       mIfCnt = '0, mLsCnt = '0, mConfCnt = '0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cycleNo, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstVal);
        lsOp_t op;
        @(negedge clk);
        rst = rstVal;
        if (ifActive && (sIfRvalid || (ifCurDrop && sIfGnt))) ifActive = 1'b0;
        if (!ifActive && ifQ.size() > 0) begin
            if_addr   = ifQ.pop_front();
            ifCurDrop = ifDropQ.pop_front();
            ifActive  = 1'b1;
        end
        if (lsActive && sLsRvalid) lsActive = 1'b0;
        if (!lsActive && lsQ.size() > 0) begin
            op       = lsQ.pop_front();
            ls_we    = op.we;
            ls_addr  = op.addr;
            ls_wdata = op.wdata;
            lsActive = 1'b1;
        end
        if_req = ifActive;
        ls_req = lsActive;
    endtask

    task automatic pushIf(input logic [ADDR_W-1:0] a, input logic drop);
        ifQ.push_back(a);
        ifDropQ.push_back(drop);
    endtask

    task automatic pushLs(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        lsOp_t op;
        op.we = we; op.addr = a; op.wdata = d;
        lsQ.push_back(op);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((ifActive || lsActive || ifQ.size() > 0 || lsQ.size() > 0 || mBusy) && n < 300) begin
            applyStimulus(1'b0);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("[TB] FAIL drain_%s timeout actual=%0d cycles required<300", tag, n);
        end
    endtask

    // Memory responder plus per-cycle comparison of every output against the model.
    always begin
        logic eIfGnt, eLsGnt, eMemEn, eMemWe, eIfRv, eLsRv, eStall, lsWins, doneNow;
        logic [DATA_W-1:0] eAddr, eWdata, eIfRd, eLsRd, ld;
        @(negedge clk);
        #1;
        mem_rdata = respSched.exists(cycleNo) ? respSched[cycleNo] : 32'hA5A5_5A5A;
        #2;
        eIfGnt = 0; eLsGnt = 0; eMemEn = 0; eMemWe = 0; eIfRv = 0; eLsRv = 0; eStall = 0;
        eAddr = '0; eWdata = '0; eIfRd = '0; eLsRd = '0; lsWins = 0; doneNow = 0;
        if (!rst) begin
            if (!mBusy && (if_req || ls_req)) begin
                lsWins = ls_req && !(if_req && mLosses == STARVE_MAX);
                eMemEn = 1;
                if (lsWins) begin
                    eLsGnt = 1; eMemWe = ls_we; eAddr = ls_addr; eWdata = ls_wdata;
                end else begin
                    eIfGnt = 1; eAddr = if_addr;
                end
            end else if (mBusy && cycleNo == mIssueCyc + MEM_LAT) begin
                doneNow = 1;
                if (mOwnerLs) begin
                    eLsRv = 1; eLsRd = mStore ? '0 : mData;
                end else begin
                    eIfRv = 1; eIfRd = mData;
                end
            end
            eStall = (if_req && !eIfRv) || (ls_req && !eLsRv);
        end
        checkOutput("if_gnt", 32'(if_gnt), 32'(eIfGnt));
        checkOutput("ls_gnt", 32'(ls_gnt), 32'(eLsGnt));
        checkOutput("mem_en", 32'(mem_en), 32'(eMemEn));
        checkOutput("mem_we", 32'(mem_we), 32'(eMemWe));
        checkOutput("mem_addr", mem_addr, eAddr);
        checkOutput("mem_wdata", mem_wdata, eWdata);
        checkOutput("if_rvalid", 32'(if_rvalid), 32'(eIfRv));
        checkOutput("ls_rvalid", 32'(ls_rvalid), 32'(eLsRv));
        checkOutput("if_rdata", if_rdata, eIfRd);
        checkOutput("ls_rdata", ls_rdata, eLsRd);
        checkOutput("stall", 32'(stall), 32'(eStall));
`ifdef ARB_STATS_EN
        checkOutput("if_gnt_cnt", 32'(if_gnt_cnt), 32'(mIfCnt));
        checkOutput("ls_gnt_cnt", 32'(ls_gnt_cnt), 32'(mLsCnt));
        checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(mConfCnt));
`endif
        sIfRvalid = if_rvalid;
        sIfGnt    = if_gnt;
        sLsRvalid = ls_rvalid;
        if (mem_en) begin
            if (mem_we) physMem[mem_addr] = mem_wdata;
            else respSched[cycleNo + MEM_LAT] = physMem.exists(mem_addr) ? physMem[mem_addr] : '0;
        end
        if (rst) begin
            mBusy = 0; mLosses = 0;
`ifdef ARB_STATS_EN
            mIfCnt = '0; mLsCnt = '0; mConfCnt = '0;
`endif
        end else if (eMemEn) begin
            mBusy = 1; mIssueCyc = cycleNo; mOwnerLs = lsWins; mStore = lsWins && ls_we;
            ld = modelMem.exists(eAddr) ? modelMem[eAddr] : '0;
            mData = ld;
            if (mStore) modelMem[eAddr] = eWdata;
            if (!lsWins) mLosses = 0;
            else if (if_req) mLosses = (mLosses == STARVE_MAX) ? STARVE_MAX : mLosses + 1;
`ifdef ARB_STATS_EN
            if (!lsWins && mIfCnt != 16'hFFFF) mIfCnt++;
            if (lsWins && mLsCnt != 16'hFFFF) mLsCnt++;
            if (if_req && ls_req && mConfCnt != 16'hFFFF) mConfCnt++;
`endif
        end else if (doneNow) begin
            mBusy = 0;
        end else if (!mBusy && !if_req) begin
            mLosses = 0;
        end
        cycleNo++;
    end

    initial begin
        logic [ADDR_W-1:0] a;
        physMem[32'h10] = 32'hDEAD_BEEF;  modelMem[32'h10] = 32'hDEAD_BEEF;
        physMem[32'h14] = 32'h1111_2222;  modelMem[32'h14] = 32'h1111_2222;
        physMem[32'h24] = 32'hCAFE_F00D;  modelMem[32'h24] = 32'hCAFE_F00D;
        physMem[32'h30] = 32'h3333_4444;  modelMem[32'h30] = 32'h3333_4444;
        for (int i = 0; i < 6; i++) begin
            a = 32'h34 + 32'(4 * i);
            physMem[a] = 32'h1000_0000 + a;
            modelMem[a] = 32'h1000_0000 + a;
        end
        for (int i = 0; i < 5; i++) begin
            a = 32'h40 + 32'(4 * i);
            physMem[a] = 32'h2000_0000 + a;
            modelMem[a] = 32'h2000_0000 + a;
        end

        $display("[TB] reset with IF request pending, then back-to-back fetches");
        pushIf(32'h10, 1'b0);
        pushIf(32'h14, 1'b0);
        applyStimulus(1'b1); #4;
        checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        applyStimulus(1'b1); #4;
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        applyStimulus(1'b0); #4;
        checkOutput("first_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("first_mem_addr", mem_addr, 32'h10);
        checkOutput("first_stall", 32'(stall), 32'd1);
        applyStimulus(1'b0); #4;
        checkOutput("wait_stall", 32'(stall), 32'd1);
        applyStimulus(1'b0); #4;
        checkOutput("fetch_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0); #4;
        checkOutput("next_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("next_mem_addr", mem_addr, 32'h14);
        drain("fetch");

        $display("[TB] both requesting: LS store, LS load, then IF");
        pushLs(1'b1, 32'h20, 32'h55);
        pushLs(1'b0, 32'h24, 32'h0);
        pushIf(32'h30, 1'b0);
        applyStimulus(1'b0); #4;
        checkOutput("store_ls_gnt", 32'(ls_gnt), 32'd1);
        checkOutput("store_mem_we", 32'(mem_we), 32'd1);
        checkOutput("store_mem_wdata", mem_wdata, 32'h55);
        applyStimulus(1'b0);
        applyStimulus(1'b0); #4;
        checkOutput("store_rvalid", 32'(ls_rvalid), 32'd1);
        checkOutput("store_rdata", ls_rdata, 32'd0);
        applyStimulus(1'b0); #4;
        checkOutput("load_ls_gnt", 32'(ls_gnt), 32'd1);
        checkOutput("load_mem_addr", mem_addr, 32'h24);
        applyStimulus(1'b0);
        applyStimulus(1'b0); #4;
        checkOutput("load_rdata", ls_rdata, 32'hCAFE_F00D);
        applyStimulus(1'b0); #4;
        checkOutput("late_if_gnt", 32'(if_gnt), 32'd1);
        drain("mixed");

        $display("[TB] starvation: LS keeps requesting while IF waits");
        pushLs(1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 5; i++) pushLs(1'b0, 32'h40 + 32'(4 * i), 32'h0);
        pushIf(32'h34, 1'b0);
        pushIf(32'h38, 1'b0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0); #4;
            if (k == 0 || k == 3 || k == 6 || k == 9) checkOutput("starve_ls_gnt", 32'(ls_gnt), 32'd1);
            if (k == 2) checkOutput("stored_readback", ls_rdata, 32'h55);
            if (k == 12) checkOutput("starve_if_gnt", 32'(if_gnt), 32'd1);
            if (k == 15) checkOutput("resume_ls_gnt", 32'(ls_gnt), 32'd1);
        end
        drain("starve");

        $display("[TB] reset during an outstanding load");
        pushLs(1'b0, 32'h24, 32'h0);
        applyStimulus(1'b0); #4;
        checkOutput("abort_ls_gnt", 32'(ls_gnt), 32'd1);
        applyStimulus(1'b1); #4;
        checkOutput("abort_rst_stall", 32'(stall), 32'd0);
        applyStimulus(1'b0); #4;
        checkOutput("abort_no_rvalid", 32'(ls_rvalid), 32'd0);
        checkOutput("abort_reissue", 32'(ls_gnt), 32'd1);
        drain("abort");

        $display("[TB] IF request dropped after grant");
        pushIf(32'h10, 1'b1);
        applyStimulus(1'b0); #4;
        checkOutput("drop_if_gnt", 32'(if_gnt), 32'd1);
        applyStimulus(1'b0); #4;
        checkOutput("drop_stall", 32'(stall), 32'd0);
        applyStimulus(1'b0); #4;
        checkOutput("drop_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("drop_rdata", if_rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0); #4;
        checkOutput("drop_not_reserved", 32'(mem_en), 32'd0);
        drain("drop");
        applyStimulus(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
